// File: rtl/if_id_queue_pkg.sv
// Shared types and hazard codes for the IF/ID prefetch queue.
package if_id_queue_pkg;

  localparam int unsigned HZ_W   = 4;
  localparam int unsigned INST_W = 32;
  localparam int unsigned PC_W   = 32;

  localparam logic [HZ_W-1:0] HZ_NONE     = 4'd0;
  localparam logic [HZ_W-1:0] STALL_MMU   = 4'd1;
  localparam logic [HZ_W-1:0] STALL_EARLY = 4'd2;
  localparam logic [HZ_W-1:0] FLUSH_EARLY = 4'd3;
  localparam logic [HZ_W-1:0] FLUSH_ALL   = 4'd4;

  localparam logic [INST_W-1:0] NOP_ENC = 32'h00000013;

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [PC_W-1:0]   pc;
    logic              fault;
  } ifq_entry_t;

  function automatic logic is_flush(input logic [HZ_W-1:0] hz);
    return (hz == FLUSH_EARLY) || (hz == FLUSH_ALL);
  endfunction

  function automatic logic is_stall(input logic [HZ_W-1:0] hz);
    return (hz == STALL_MMU) || (hz == STALL_EARLY);
  endfunction

endpackage

// File: rtl/if_queue_mem.sv
// Queue storage: one synchronous write port, one asynchronous read port.
module if_queue_mem
  import if_id_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  ifq_entry_t               wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output ifq_entry_t               rdata
);

  ifq_entry_t mem [DEPTH];

  // Contents need no reset; validity is tracked by the occupancy count.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/if_id_queue.sv
// Instruction prefetch queue and IF/ID boundary register.
// Optional same-cycle fetch-to-decode bypass when IFQ_BYPASS_EN is defined.
module if_id_queue
  import if_id_queue_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] NOP_INST = 32'h00000013
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [HZ_W-1:0]            hazard_signal,
  input  logic                       fence_active,
  input  logic                       fetch_valid,
  output logic                       fetch_ready,
  input  logic [INST_W-1:0]          fetch_inst,
  input  logic [PC_W-1:0]            fetch_pc,
  input  logic                       fetch_fault,
  output logic                       IF_valid,
  output logic [INST_W-1:0]          IFinstruction,
  output logic [PC_W-1:0]            IFpc,
  output logic                       IF_fault,
  output logic [4:0]                 rs1,
  output logic [4:0]                 rs2,
  output logic [4:0]                 rd,
  output logic [$clog2(DEPTH):0]     queue_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] count;
  logic             flush, hold, stored_valid, bypass, push, pop;
  ifq_entry_t       wdata, head;

  assign flush        = is_flush(hazard_signal);
  assign hold         = is_stall(hazard_signal) | fence_active;
  assign stored_valid = (count != '0);
  assign fetch_ready  = (count != CNT_W'(DEPTH)) && !flush;

`ifdef IFQ_BYPASS_EN
  // An empty queue hands the fetch entry straight to decode when it will be consumed.
  assign bypass = !stored_valid && fetch_valid && !hold && !flush;
`else
  assign bypass = 1'b0;
`endif

  assign push  = fetch_valid && fetch_ready && !bypass;
  assign pop   = stored_valid && !hold && !flush;
  assign wdata = '{inst: fetch_inst, pc: fetch_pc, fault: fetch_fault};

  if_queue_mem #(.DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (wdata),
    .raddr (rd_ptr),
    .rdata (head)
  );

  // Pointer and occupancy update; flush discards everything and rewinds.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Head presentation: stored entry, else bypassed fetch, else NOP.
  always_comb begin
    IF_valid      = 1'b0;
    IFinstruction = NOP_INST;
    IFpc          = '0;
    IF_fault      = 1'b0;
    if (stored_valid) begin
      IF_valid      = 1'b1;
      IFinstruction = head.inst;
      IFpc          = head.pc;
      IF_fault      = head.fault;
    end else if (bypass) begin
      IF_valid      = 1'b1;
      IFinstruction = fetch_inst;
      IFpc          = fetch_pc;
      IF_fault      = fetch_fault;
    end
  end

  assign rs1         = IFinstruction[19:15];
  assign rs2         = IFinstruction[24:20];
  assign rd          = IFinstruction[11:7];
  assign queue_count = count;

endmodule
